// File: rtl/ram_dp_param.sv
// True dual-port synchronous RAM with byte enables, selectable read-during-write,
// optional output register and a one-word-per-cycle clear sweep.
module ram_dp_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    output logic                busy,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_valid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_din,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_valid
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              start_clear, accept, flush, clr_we, same_addr;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]             en_p, we_p, wr_p, rd_fire, src_vld;
    logic [1:0][BE_W-1:0]   be_p;
    logic [1:0][ADDR_W-1:0] addr_p;
    logic [1:0][DATA_W-1:0] din_p, old_p, new_p, rd_word, src_data;
    logic [1:0]             p1_vld_q, p1_vld_d, valid_q, valid_d;
    logic [1:0][DATA_W-1:0] p1_data_q, p1_data_d, dout_q, dout_d;

    logic [DATA_W-1:0] mem [DEPTH];

    assign en_p   = {b_en, a_en};
    assign we_p   = {b_we, a_we};
    assign be_p   = {b_be, a_be};
    assign addr_p = {b_addr, a_addr};
    assign din_p  = {b_din, a_din};

    assign a_dout  = dout_q[0];
    assign b_dout  = dout_q[1];
    assign a_valid = valid_q[0];
    assign b_valid = valid_q[1];

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        busy        = rst || (state_q == CLEAR);
        start_clear = !busy && init;
        accept      = !busy && !init;
        flush       = rst || start_clear;
        clr_we      = (state_q == CLEAR) && !rst;
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        if (rst) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end else if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) state_d = IDLE;
        end else if (init) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end
    end

    always_comb begin
        same_addr = (addr_p[0] == addr_p[1]);
        for (int p = 0; p < 2; p++) begin
            wr_p[p]  = accept && en_p[p] && we_p[p];
            old_p[p] = mem[addr_p[p]];
            new_p[p] = old_p[p];
        end
        // Merged post-write word: B bytes first, then A bytes on top so A wins a collision.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_p[1] && (p == 1 || same_addr) && be_p[1][i])
                    new_p[p][8*i +: 8] = din_p[1][8*i +: 8];
            end
            for (int i = 0; i < BE_W; i++) begin
                if (wr_p[0] && (p == 0 || same_addr) && be_p[0][i])
                    new_p[p][8*i +: 8] = din_p[0][8*i +: 8];
            end
        end
        for (int p = 0; p < 2; p++) begin
            rd_fire[p]   = accept && en_p[p] && (!we_p[p] || (RDW_MODE != 0 && |be_p[p]));
            rd_word[p]   = we_p[p] ? new_p[p] : old_p[p];
            p1_vld_d[p]  = rd_fire[p];
            p1_data_d[p] = rd_fire[p] ? rd_word[p] : p1_data_q[p];
            if (OUT_REG != 0) begin
                src_vld[p]  = p1_vld_q[p] && !flush;
                src_data[p] = p1_data_q[p];
            end else begin
                src_vld[p]  = rd_fire[p];
                src_data[p] = rd_word[p];
            end
            valid_d[p] = src_vld[p];
            dout_d[p]  = src_vld[p] ? src_data[p] : dout_q[p];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            p1_vld_q   <= '0;
            p1_data_q  <= '0;
            valid_q    <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            p1_vld_q   <= p1_vld_d;
            p1_data_q  <= p1_data_d;
            valid_q    <= valid_d;
            dout_q     <= dout_d;
        end
    end

    // NOTE: the array itself has no reset; zeroing it is the clear sweep's job.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_p[p] && be_p[p][i])
                        mem[addr_p[p]][8*i +: 8] <= din_p[p][8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: three shared-stimulus instances (read-first, write-first,
// output-registered) checked against a scoreboard fed by a behavioural memory model.
module tb_ram_dp_param;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [1:0]  be;
        logic [5:0]  addr;
        logic [15:0] din;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0;
    req_t ra = '0;
    req_t rb = '0;

    // Scoreboard index = instance*2 + port (port 0 = A, 1 = B).
    logic [2:0]       busy_w;
    logic [5:0]       valid_w;
    logic [5:0][15:0] dout_w;

    logic [15:0] model_mem [DEPTH];
    bit          model_clear = 1'b1;
    int          model_caddr = 0;
    int          cyc = 0;
    exp_t        sb [6][$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n;

    always #5 clk = ~clk;

    ram_dp_param #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .init(init), .busy(busy_w[0]),
        .a_en(ra.en), .a_we(ra.we), .a_be(ra.be), .a_addr(ra.addr), .a_din(ra.din),
        .a_dout(dout_w[0]), .a_valid(valid_w[0]),
        .b_en(rb.en), .b_we(rb.we), .b_be(rb.be), .b_addr(rb.addr), .b_din(rb.din),
        .b_dout(dout_w[1]), .b_valid(valid_w[1]));

    ram_dp_param #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(0)) u_dut1 (
        .clk(clk), .rst(rst), .init(init), .busy(busy_w[1]),
        .a_en(ra.en), .a_we(ra.we), .a_be(ra.be), .a_addr(ra.addr), .a_din(ra.din),
        .a_dout(dout_w[2]), .a_valid(valid_w[2]),
        .b_en(rb.en), .b_we(rb.we), .b_be(rb.be), .b_addr(rb.addr), .b_din(rb.din),
        .b_dout(dout_w[3]), .b_valid(valid_w[3]));

    ram_dp_param #(.DATA_W(16), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .init(init), .busy(busy_w[2]),
        .a_en(ra.en), .a_we(ra.we), .a_be(ra.be), .a_addr(ra.addr), .a_din(ra.din),
        .a_dout(dout_w[4]), .a_valid(valid_w[4]),
        .b_en(rb.en), .b_we(rb.we), .b_be(rb.be), .b_addr(rb.addr), .b_din(rb.din),
        .b_dout(dout_w[5]), .b_valid(valid_w[5]));

    function automatic req_t idle();
        return '0;
    endfunction

    function automatic req_t rd(input int addr);
        req_t r = '0;
        r.en   = 1'b1;
        r.addr = 6'(addr);
        return r;
    endfunction

    function automatic req_t wr(input int addr, input logic [15:0] din, input logic [1:0] be);
        req_t r = '0;
        r.en   = 1'b1;
        r.we   = 1'b1;
        r.be   = be;
        r.addr = 6'(addr);
        r.din  = din;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int q, input logic [15:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        sb[q].push_back(e);
    endtask

    // Drop output-register results still in flight when a sweep starts or reset hits.
    task automatic flush_oreg();
        for (int q = 4; q < 6; q++)
            while (sb[q].size() > 0 && sb[q][sb[q].size()-1].due >= cyc) void'(sb[q].pop_back());
    endtask

    task automatic monitor();
        exp_t e;
        for (int k = 0; k < 3; k++)
            check($sformatf("busy_i%0d", k), {31'b0, busy_w[k]}, {31'b0, model_clear || rst});
        for (int q = 0; q < 6; q++) begin
            if (sb[q].size() > 0 && sb[q][0].due == cyc) begin
                e = sb[q].pop_front();
                check($sformatf("valid_i%0d_p%0d", q / 2, q % 2), {31'b0, valid_w[q]}, 32'd1);
                check($sformatf("dout_i%0d_p%0d", q / 2, q % 2), {16'b0, dout_w[q]}, {16'b0, e.data});
            end else begin
                check($sformatf("novalid_i%0d_p%0d", q / 2, q % 2), {31'b0, valid_w[q]}, 32'd0);
            end
        end
    endtask

    task automatic model_update(input logic rst_i, input logic init_i, input req_t a, input req_t b);
        req_t r;
        if (rst_i) begin
            model_clear = 1'b1;
            model_caddr = 0;
            flush_oreg();
        end else if (model_clear) begin
            model_mem[model_caddr] = '0;
            model_caddr++;
            if (model_caddr == DEPTH) begin
                model_clear = 1'b0;
                model_caddr = 0;
            end
        end else if (init_i) begin
            model_clear = 1'b1;
            model_caddr = 0;
            flush_oreg();
        end else begin
            for (int p = 0; p < 2; p++) begin
                r = (p == 0) ? a : b;
                if (r.en && !r.we) begin
                    push(p, model_mem[r.addr], cyc);
                    push(2 + p, model_mem[r.addr], cyc);
                    push(4 + p, model_mem[r.addr], cyc + 1);
                end
            end
            for (int p = 1; p >= 0; p--) begin
                r = (p == 0) ? a : b;
                for (int i = 0; i < 2; i++)
                    if (r.en && r.we && r.be[i]) model_mem[r.addr][8*i +: 8] = r.din[8*i +: 8];
            end
            for (int p = 0; p < 2; p++) begin
                r = (p == 0) ? a : b;
                if (r.en && r.we && |r.be) push(2 + p, model_mem[r.addr], cyc);
            end
        end
    endtask

    task automatic step(input logic rst_i, input logic init_i, input req_t a, input req_t b);
        @(negedge clk);
        monitor();
        rst  = rst_i;
        init = init_i;
        ra   = a;
        rb   = b;
        @(posedge clk);
        cyc++;
        model_update(rst_i, init_i, a, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'hDEAD;

        repeat (3) step(1'b1, 1'b0, idle(), idle());
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rst_dout%0d", k), {16'b0, dout_w[k]}, 32'd0);
            check($sformatf("rst_valid%0d", k), {31'b0, valid_w[k]}, 32'd0);
        end
        check("rst_busy", {29'b0, busy_w}, 32'h7);

        // Sweep after reset release lasts DEPTH cycles.
        step(1'b0, 1'b0, idle(), idle());
        #1;
        n = 1;
        while (busy_w[0] === 1'b1 && n < 200) begin
            step(1'b0, 1'b0, rd(n), rd(n));
            #1;
            n++;
        end
        check("busy_len_reset", n, DEPTH);

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, rd(i), rd(DEPTH - 1 - i));
        #1;
        check("sweep_read_valid", {31'b0, valid_w[0]}, 32'd1);
        check("sweep_read_zero", {16'b0, dout_w[1]}, 32'd0);

        // Byte-enable writes seen by the other port.
        step(1'b0, 1'b0, wr(5, 16'hABCD, 2'b11), idle());
        step(1'b0, 1'b0, idle(), rd(5));
        #1;
        check("b_read5_full", {16'b0, dout_w[1]}, 32'hABCD);
        step(1'b0, 1'b0, wr(5, 16'h1234, 2'b01), idle());
        step(1'b0, 1'b0, rd(5), rd(5));
        #1;
        check("b_read5_low_byte", {16'b0, dout_w[1]}, 32'hAB34);

        // Cross-port read during write returns old data.
        step(1'b0, 1'b0, wr(9, 16'h5555, 2'b11), rd(9));
        #1;
        check("cross_old", {16'b0, dout_w[1]}, 32'h0000);
        check("cross_old_valid", {31'b0, valid_w[1]}, 32'd1);
        step(1'b0, 1'b0, idle(), rd(9));
        #1;
        check("cross_next", {16'b0, dout_w[1]}, 32'h5555);

        // Same-address write collision.
        step(1'b0, 1'b0, wr(3, 16'h1111, 2'b10), wr(3, 16'h2222, 2'b11));
        step(1'b0, 1'b0, rd(3), idle());
        #1;
        check("collision", {16'b0, dout_w[0]}, 32'h1122);

        // Write-first returns the merged word; read-first gives no valid on a write.
        step(1'b0, 1'b0, wr(12, 16'hAB00, 2'b11), idle());
        step(1'b0, 1'b0, wr(12, 16'h00FF, 2'b01), idle());
        #1;
        check("wf_dout", {16'b0, dout_w[2]}, 32'hABFF);
        check("wf_valid", {31'b0, valid_w[2]}, 32'd1);
        check("rf_novalid", {31'b0, valid_w[0]}, 32'd0);
        step(1'b0, 1'b0, wr(12, 16'hFFFF, 2'b00), idle());
        #1;
        check("be0_novalid", {31'b0, valid_w[2]}, 32'd0);
        step(1'b0, 1'b0, rd(12), idle());
        #1;
        check("be0_nowrite", {16'b0, dout_w[0]}, 32'hABFF);

        // Continuous reads with init mid-stream: in-flight output-register reads are dropped.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, rd(i), rd(5 - i));
        step(1'b0, 1'b1, rd(5), rd(9));
        #1;
        check("init_flush_valid", {31'b0, valid_w[4]}, 32'd0);
        check("init_hold_dout", {16'b0, dout_w[4]}, 32'h1122);
        n = 0;
        while (busy_w[2] === 1'b1 && n < 200) begin
            step(1'b0, 1'b0, rd(n % DEPTH), rd(3));
            #1;
            n++;
        end
        check("busy_len_init", n, DEPTH);
        step(1'b0, 1'b0, rd(3), rd(12));
        step(1'b0, 1'b0, rd(5), rd(9));
        #1;
        check("post_clear_oreg", {16'b0, dout_w[4]}, 32'h0000);
        step(1'b0, 1'b0, idle(), idle());
        #1;
        check("post_clear_oreg_b", {16'b0, dout_w[5]}, 32'h0000);

        // Reset at sweep address 30 restarts the sweep.
        step(1'b0, 1'b0, wr(40, 16'h7777, 2'b11), idle());
        step(1'b0, 1'b0, rd(40), rd(40));
        step(1'b0, 1'b1, idle(), idle());
        repeat (30) step(1'b0, 1'b0, idle(), idle());
        step(1'b1, 1'b0, idle(), idle());
        #1;
        for (int k = 0; k < 6; k++)
            check($sformatf("midrst_dout%0d", k), {16'b0, dout_w[k]}, 32'd0);
        n = 0;
        while (busy_w[0] === 1'b1 && n < 200) begin
            step(1'b0, 1'b0, idle(), idle());
            #1;
            n++;
        end
        check("busy_len_midrst", n, DEPTH);
        step(1'b0, 1'b0, rd(40), rd(0));
        repeat (3) step(1'b0, 1'b0, idle(), idle());

        for (int q = 0; q < 6; q++)
            check($sformatf("sb_drained%0d", q), sb[q].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised true dual-port synchronous RAM with per-port byte-enable writes, selectable read-during-write behaviour, an optional output register stage and a built-in sequential clear engine. It is the general-purpose storage primitive for buffers, lookup tables and register files across the design. The clear engine replaces single-cycle whole-array reset with a one-word-per-cycle zeroing sweep, with a busy flag exposed to clients.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 6: address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0: same-port read-during-write result; 0 = old data (read-first), 1 = new data (write-first).
- OUT_REG, 0: 1 adds an output register; read latency becomes 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- init  in  1  one-cycle request to start a clear sweep.
- busy  out  1  clear sweep in progress; port requests are ignored.
- a_en, b_en  in  1  port access enable.
- a_we, b_we  in  1  write (1) or read (0); meaningful only with en.
- a_be, b_be  in  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i].
- a_addr, b_addr  in  ADDR_W  word address.
- a_din, b_din  in  DATA_W  write data.
- a_dout, b_dout  out  DATA_W  read data.
- a_valid, b_valid  out  1  one-cycle pulse aligned with new dout.

## Operation
- States: CLEAR, IDLE. rst forces CLEAR with clear address 0; rst held keeps address at 0.
- CLEAR: each cycle writes zero to the clear address and increments it; after writing DEPTH-1 goes to IDLE. busy = 1 in CLEAR and while rst is asserted.
- IDLE: init = 1 enters CLEAR at address 0; port requests in that same cycle are dropped. init is ignored while busy.
- Requests are accepted only in cycles where busy = 0 and init = 0. Dropped requests produce no write and no valid.
- Write (en=1, we=1): bytes with be=1 updated; be=0 bytes retain contents. be = 0 writes nothing but still counts as a write access (no valid).
- Read (en=1, we=0): mem[addr] returned on dout with valid pulse.
- Same-port read-during-write is not possible (we selects one); with RDW_MODE=1 a write also returns merged new word on dout with valid; with RDW_MODE=0 a write produces no dout change and no valid.
- Cross-port: read on one port to address being written by the other in the same cycle returns old data in all modes.
- Write-write collision, same address: port A bytes win where a_be=1; bytes with only b_be=1 take port B data.
- dout holds its last value when no new read completes; cleared to 0 by rst only (not by init).

## Timing
- Reset values: a_dout = b_dout = 0, a_valid = b_valid = 0, busy = 1.
- busy stays high for exactly DEPTH cycles after the first clock edge with rst = 0; same for init (DEPTH cycles starting the cycle after init sampled).
- Read latency: request at edge N -> dout/valid updated after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Back-to-back reads every cycle sustained, one result per cycle per port.
- Write visible to a read on either port issued at the next edge.
- With OUT_REG=1, rst or start of CLEAR flushes the pipeline: in-flight reads produce no valid.
- Reset mid-sweep restarts the sweep from address 0.

## Test plan
- Reset release with ADDR_W=6 -> busy high for 64 cycles, then low; read of every address on both ports returns 0x0000 with valid after 1 cycle.
- Port A write addr 5 data 0xABCD be=11, then port B read addr 5 -> b_dout = 0xABCD; then A write 0x1234 be=01 -> read returns 0xAB34.
- Same-cycle A write addr 9 = 0x5555 and B read addr 9 (old 0x0000) -> b_dout = 0x0000; next-cycle B read -> 0x5555.
- Both ports write addr 3, A = 0x1111 be=10, B = 0x2222 be=11 -> mem[3] = 0x1122.
- RDW_MODE=1, write 0x00FF be=01 over 0xAB00 -> dout = 0xABFF with valid; RDW_MODE=0 -> no valid.
- OUT_REG=1 continuous reads, assert init mid-stream -> in-flight valids suppressed, busy 64 cycles, subsequent reads return 0; rst at sweep address 30 -> sweep restarts, busy 64 more cycles.
